mem_stage_mc: RTL and testbench
===============================

Name: mem_stage_mc

Overview:
- Memory stage for the multi-cycle-memory generation of the pipeline. Replaces the single-cycle memory stage.
- Issues loads and stores to an external variable-latency memory through a req/done handshake. Stalls the pipeline while an access is outstanding.
- Returns load data with a valid strobe and flags timeouts as errors.
- Resolves the next PC (sequential / branch target / ALU jump) for the fetch stage.
- Sits between the execute/memory pipeline register and the memory/writeback register.

Parameters:
- DATA_W, 16, data path width in bits.
- ADDR_W, 16, address and PC width in bits.
- MAX_WAIT, 15, maximum cycles in WAIT before timeout (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  pipeline slot carries a live instruction.
- rd_en  in  1  instruction is a load.
- wr_en  in  1  instruction is a store (rd_en & wr_en is illegal; treat as store).
- halt  in  1  instruction is HALT.
- addr  in  ADDR_W  effective address from the ALU; also the jump target.
- wdata  in  DATA_W  store data.
- in_pc  in  ADDR_W  PC+2 of this instruction.
- offset  in  ADDR_W  sign-extended branch offset.
- brch_taken  in  1  branch condition true.
- alu_jmp  in  1  jump to addr.
- stall  out  1  hold upstream stages this cycle.
- rdata  out  DATA_W  load result, held until the next completion.
- rdata_valid  out  1  one-cycle pulse when rdata updates.
- err  out  1  one-cycle pulse on timeout (or misalignment, see Optional Feature).
- dump  out  1  one-cycle pulse on accepted HALT; drives memory createdump.
- next_pc  out  ADDR_W  resolved next PC.
- mem_req  out  1  request to the external memory.
- mem_wr  out  1  request is a write.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  request write data.
- mem_done  in  1  memory completed the current request.
- mem_rdata  in  DATA_W  read data, valid with mem_done.

Behaviour:
- States:
  - IDLE: no access outstanding.
  - WAIT: request outstanding.
  - DONE: one-cycle completion slot.
- Accept condition: `acc = in_valid & (rd_en|wr_en) & ~halt & state∈{IDLE,DONE}`.
- On acc:
  - Latch addr, wdata and wr_en into request registers.
  - Next state is WAIT; mem_req is 1 from the next cycle.
  - stall = 1 combinationally in the acceptance cycle.
- In WAIT:
  - mem_req = 1 and stall = 1.
  - mem_addr, mem_wr and mem_wdata are stable.
  - Wait counter increments each cycle.
- mem_done in WAIT:
  - Read: rdata ← mem_rdata and rdata_valid pulses in the next cycle. Write: rdata unchanged, no rdata_valid.
  - mem_req deasserts next cycle; state goes to DONE, where stall = 0 unless a new acc.
- Timeout: if the counter reaches MAX_WAIT without mem_done:
  - err pulses.
  - rdata ← 0 for reads, with no rdata_valid.
  - State goes to IDLE and mem_req drops.
- mem_done and the timeout in the same cycle: mem_done wins.
- mem_done seen in IDLE or DONE is ignored.
- DONE goes to IDLE, unless acc occurs, in which case it goes to WAIT.
- HALT: `in_valid & halt` in IDLE/DONE causes dump to pulse in the next cycle, with no memory access and no stall. HALT presented while in WAIT is held off by stall.
- next_pc is combinational:
  - alu_jmp → addr;
  - else brch_taken → in_pc + offset (mod 2^ADDR_W, carry discarded);
  - else in_pc.
  - It is only meaningful when stall = 0.
- Reset:
  - state = IDLE, counter = 0.
  - mem_req, mem_wr, stall (registered part), rdata_valid, err and dump all 0.
  - rdata = 0; mem_addr = 0, mem_wdata = 0.
  - Reset mid-WAIT drops mem_req at the next edge; a late mem_done is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - On acc with addr[0] = 1, no request is issued.
  - err pulses the next cycle; state goes to DONE.
  - stall is asserted only in the acceptance cycle, and rdata is unchanged.
- Undefined: no alignment check; mem_addr = addr unmodified.

Decomposition:
- Package mem_stage_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - default DATA_W/ADDR_W constants;
  - the counter width derived from MAX_WAIT.
- Sub-module pc_resolve holds the next-PC adder and the two-level select; it is purely combinational.

Test Plan:
- Load addr=0x0010, mem_done after 3 WAIT cycles with mem_rdata=0xBEEF → stall high for 4 cycles, then rdata=0xBEEF and rdata_valid pulses once; mem_req high exactly 3 cycles.
- Store addr=0x0020, wdata=0x1234, immediate mem_done → mem_wr=1, mem_wdata=0x1234; no rdata_valid; rdata unchanged.
- Load with mem_done never asserted, MAX_WAIT=15 → err pulse after 15 WAIT cycles; rdata=0, state IDLE, mem_req low.
- in_pc=0xFFFE, offset=0x0004, brch_taken=1 → next_pc=0x0002. alu_jmp=1, addr=0x4000 → next_pc=0x4000 regardless of brch_taken.
- rst asserted on the 2nd WAIT cycle, then mem_done on the following cycle → mem_req low after the edge, no rdata_valid, all outputs at reset values.
- HALT in IDLE → dump pulses once, stall stays 0. With MEM_ALIGN_CHECK_EN defined, a load at addr=0x0011 → err pulse, mem_req never asserted.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and defaults for the multi-cycle memory stage.
// Holds the access state enum, default data/address widths and the wait
// counter width derivation used by mem_stage_mc.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no access outstanding
    WAIT = 2'd1,  // request outstanding at the external memory
    DONE = 2'd2   // one-cycle completion slot
  } state_t;

  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 15;

  // Width needed to hold a wait count in 0..max_wait.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(MAX_WAIT_DEF);

endpackage

// File: rtl/pc_resolve.sv
// pc_resolve: combinational next-PC select for the fetch stage.
// Ports: alu_jmp/brch_taken select the source; addr is the jump target,
//        in_pc is PC+2, offset is the sign-extended branch offset; next_pc out.
module pc_resolve
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              alu_jmp,
  input  logic              brch_taken,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] br_target;

  // Same-width add: the carry out is dropped, so targets wrap mod 2^ADDR_W.
  assign br_target = in_pc + offset;

  // Jump has priority over a taken branch.
  always_comb begin
    next_pc = in_pc;
    if (alu_jmp) begin
      next_pc = addr;
    end else if (brch_taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: memory stage issuing loads/stores to a variable-latency memory
// over a req/done handshake, stalling the pipeline while an access is open.
// Ports: clk/rst (sync, active-high); pipeline inputs in_valid, rd_en, wr_en,
//        halt, addr, wdata, in_pc, offset, brch_taken, alu_jmp; outputs stall,
//        rdata, rdata_valid, err, dump, next_pc; memory side mem_req, mem_wr,
//        mem_addr, mem_wdata (out) and mem_done, mem_rdata (in).
// Optional macro MEM_ALIGN_CHECK_EN: odd addresses are rejected with an err
// pulse and never reach the memory.
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              halt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] offset,
  input  logic              brch_taken,
  input  logic              alu_jmp,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              dump,
  output logic [ADDR_W-1:0] next_pc,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int            CW       = cnt_width(MAX_WAIT);
  // Counter runs 0..MAX_WAIT-1, so WAIT lasts at most MAX_WAIT cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          can_accept;
  logic          acc;
  logic          halt_acc;
  logic          misalign;

  assign can_accept = (state == IDLE) || (state == DONE);
  assign acc        = in_valid & (rd_en | wr_en) & ~halt & can_accept;
  assign halt_acc   = in_valid & halt & can_accept;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = addr[0];
`else
  assign misalign = 1'b0;
`endif

  // Stall covers the acceptance cycle combinationally and every WAIT cycle.
  assign stall = acc | (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      dump        <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      dump        <= halt_acc;

      case (state)
        IDLE, DONE: begin
          if (acc) begin
            // rd_en & wr_en together is latched as a store via wr_en.
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_wr    <= wr_en;
            cnt       <= '0;
            if (misalign) begin
              err     <= 1'b1;
              mem_req <= 1'b0;
              state   <= DONE;
            end else begin
              mem_req <= 1'b1;
              state   <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end

        WAIT: begin
          // mem_done takes priority over a timeout in the same cycle.
          if (mem_done) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (!mem_wr) begin
              rdata       <= mem_rdata;
              rdata_valid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
            if (!mem_wr) begin
              rdata <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  pc_resolve #(
    .ADDR_W(ADDR_W)
  ) u_pc_resolve (
    .alu_jmp   (alu_jmp),
    .brch_taken(brch_taken),
    .addr      (addr),
    .in_pc     (in_pc),
    .offset    (offset),
    .next_pc   (next_pc)
  );

endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc: directed plus randomized bench for mem_stage_mc.
module tb_mem_stage_mc;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int MAXW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, rd_en, wr_en, halt;
  logic [AW-1:0] addr, in_pc, offset;
  logic [DW-1:0] wdata;
  logic          brch_taken, alu_jmp;
  logic          stall;
  logic [DW-1:0] rdata;
  logic          rdata_valid, err, dump;
  logic [AW-1:0] next_pc;
  logic          mem_req, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Last value a load is expected to have left on rdata.
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_stage_mc #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .halt       (halt),
    .addr       (addr),
    .wdata      (wdata),
    .in_pc      (in_pc),
    .offset     (offset),
    .brch_taken (brch_taken),
    .alu_jmp    (alu_jmp),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .err        (err),
    .dump       (dump),
    .next_pc    (next_pc),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    halt       = 1'b0;
    mem_done   = 1'b0;
    alu_jmp    = 1'b0;
    brch_taken = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".mem_req"},     32'(mem_req),     0);
    chk({tag, ".mem_wr"},      32'(mem_wr),      0);
    chk({tag, ".stall"},       32'(stall),       0);
    chk({tag, ".rdata_valid"}, 32'(rdata_valid), 0);
    chk({tag, ".err"},         32'(err),         0);
    chk({tag, ".dump"},        32'(dump),        0);
    chk({tag, ".rdata"},       32'(rdata),       0);
    chk({tag, ".mem_addr"},    32'(mem_addr),    0);
    chk({tag, ".mem_wdata"},   32'(mem_wdata),   0);
  endtask

  // One memory access at transaction level. lat = WAIT cycle on which the
  // memory answers (1 = first WAIT cycle); 0 or > MAXW means it never does.
  // With b2b set, the task returns inside the completion cycle so the next
  // access is presented from the completion slot.
  task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int lat, input logic [DW-1:0] rd, input bit b2b);
    int w;
    bit tmo;
    bit mis;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = a[0];
`endif
    if (mis) begin
      w = 0;  tmo = 1'b0;
    end else if (lat >= 1 && lat <= MAXW) begin
      w = lat; tmo = 1'b0;
    end else begin
      w = MAXW; tmo = 1'b1;
    end

    in_valid = 1'b1; rd_en = !wr; wr_en = wr; halt = 1'b0;
    addr = a; wdata = wd; mem_done = 1'b0;
    #2;
    chk("acc.stall",   32'(stall),   1);
    chk("acc.mem_req", 32'(mem_req), 0);
    tick();
    // Scramble the pipeline inputs: the request must come from latched copies.
    in_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    addr = 16'($urandom); wdata = 16'($urandom);

    for (int k = 1; k <= w; k++) begin
      mem_done  = (k == lat);
      mem_rdata = (k == lat) ? rd : 16'($urandom);
      #2;
      chk("wait.mem_req",     32'(mem_req),     1);
      chk("wait.stall",       32'(stall),       1);
      chk("wait.mem_addr",    32'(mem_addr),    32'(a));
      chk("wait.mem_wr",      32'(mem_wr),      32'(wr));
      chk("wait.mem_wdata",   32'(mem_wdata),   32'(wd));
      chk("wait.rdata_valid", 32'(rdata_valid), 0);
      chk("wait.err",         32'(err),         0);
      tick();
    end

    // A stray mem_done in the completion slot must be ignored.
    mem_done  = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    if (!wr && !mis) m_rdata = tmo ? 16'h0000 : rd;
    #2;
    chk("done.mem_req",     32'(mem_req),     0);
    chk("done.stall",       32'(stall),       0);
    chk("done.rdata_valid", 32'(rdata_valid), 32'(!wr && !mis && !tmo));
    chk("done.err",         32'(err),         32'(tmo || mis));
    chk("done.rdata",       32'(rdata),       32'(m_rdata));
    chk("done.dump",        32'(dump),        0);
    if (!b2b) begin
      tick();
      #2;
      chk("post.rdata_valid", 32'(rdata_valid), 0);
      chk("post.err",         32'(err),         0);
      chk("post.rdata",       32'(rdata),       32'(m_rdata));
      chk("post.mem_req",     32'(mem_req),     0);
      mem_done = 1'b0;
    end
  endtask

  task automatic pc_chk(input bit jmp, input bit br, input logic [AW-1:0] a,
                        input logic [AW-1:0] pc, input logic [AW-1:0] off);
    logic [AW-1:0] e;
    alu_jmp = jmp; brch_taken = br; addr = a; in_pc = pc; offset = off;
    if (jmp)     e = a;
    else if (br) e = AW'((int'(pc) + int'(off)) % 65536);
    else         e = pc;
    #1;
    chk("next_pc", 32'(next_pc), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    addr = '0; wdata = '0; in_pc = '0; offset = '0; mem_rdata = '0;
    m_rdata = '0;
    tick(); tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Directed: load with 3-cycle latency, store with immediate done, timeout.
    access(1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b0);
    access(1'b1, 16'h0020, 16'h1234, 1, 16'h0000, 1'b0);
    access(1'b0, 16'h0040, 16'h0000, 0, 16'h0000, 1'b0);
    // Done on the very cycle the timeout would fire: done wins.
    access(1'b0, 16'h0042, 16'h0000, MAXW, 16'hC0DE, 1'b0);
    // Back-to-back from the completion slot.
    access(1'b0, 16'h0050, 16'h0000, 2, 16'h1111, 1'b1);
    access(1'b1, 16'h0052, 16'h9999, 4, 16'h0000, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    access(1'b0, 16'h0011, 16'h0000, 3, 16'h5555, 1'b0);
`endif

    // next_pc directed and random.
    in_valid = 1'b0;
    pc_chk(1'b0, 1'b1, 16'h0000, 16'hFFFE, 16'h0004);
    pc_chk(1'b1, 1'b1, 16'h4000, 16'hFFFE, 16'h0004);
    pc_chk(1'b1, 1'b0, 16'h4000, 16'h0100, 16'h0004);
    pc_chk(1'b0, 1'b0, 16'h4000, 16'h0100, 16'h0004);
    for (int i = 0; i < 20; i++) begin
      pc_chk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
             16'($urandom), 16'($urandom));
    end
    alu_jmp = 1'b0; brch_taken = 1'b0;
    tick();

    // HALT in IDLE: dump pulses once, no stall, no request.
    in_valid = 1'b1; halt = 1'b1; rd_en = 1'b1;
    #2;
    chk("halt.stall",   32'(stall),   0);
    chk("halt.mem_req", 32'(mem_req), 0);
    tick();
    in_valid = 1'b0; halt = 1'b0; rd_en = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'h7777;  // ignored while idle
    #2;
    chk("halt.dump",    32'(dump),    1);
    chk("halt.mem_req", 32'(mem_req), 0);
    tick();
    mem_done = 1'b0;
    #2;
    chk("halt.dump_once",      32'(dump),        0);
    chk("idle_done.rd_valid",  32'(rdata_valid), 0);
    chk("idle_done.rdata",     32'(rdata),       32'(m_rdata));
    tick();

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      int lat;
      if ($urandom_range(0, 4) == 0) lat = int'($urandom_range(MAXW + 1, MAXW + 5));
      else                           lat = int'($urandom_range(1, MAXW));
      access(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), lat,
             16'($urandom), 1'($urandom_range(0, 1)));
    end
    mem_done = 1'b0;
    tick();

    // Reset on the 2nd WAIT cycle, late mem_done afterwards.
    in_valid = 1'b1; rd_en = 1'b1; addr = 16'h0030;
    #2;
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    #2;
    chk("rst.w1.mem_req", 32'(mem_req), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'hAAAA;
    m_rdata = '0;
    #2;
    check_reset_vals("rst");
    tick();
    mem_done = 1'b0;
    #2;
    chk("rst.late.rdata_valid", 32'(rdata_valid), 0);
    chk("rst.late.rdata",       32'(rdata),       0);
    chk("rst.late.mem_req",     32'(mem_req),     0);
    chk("rst.late.err",         32'(err),         0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
